branch_predictor: RTL

Fetch-side branch predictor for the 5-stage MIPS pipeline; the producer of predictions that the EX-stage branch comparator later resolves. It holds a direct-mapped branch target buffer (BTB) of 2-bit saturating counters, predicts taken/target for the IF-stage PC, and is trained by the resolved outcome (`bcompare_in`) in EX. It flags mispredictions and supplies the corrected fetch PC. It also keeps branch and miss performance counters.

---
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor.sv | 110 +++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/EX-side connection bundle for the branch predictor.
// The master modport is the pipeline (drives PCs and resolved outcomes).
// The slave modport is the predictor (returns predictions, redirects, counters).
interface branch_predictor_if;
  // IF-stage lookup
  logic [31:0] PC_IF;
  logic        pred_taken;
  logic [31:0] pred_target;
  // EX-stage resolution
  logic        EX_valid;
  logic [31:0] PC_EX;
  logic        bcompare_in;
  logic [31:0] target_EX;
  logic        pred_taken_EX;
  logic [31:0] pred_target_EX;
  logic        mispredict;
  logic [31:0] redirect_PC;
  // Performance counters
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  modport master (
    output PC_IF, EX_valid, PC_EX, bcompare_in, target_EX, pred_taken_EX, pred_target_EX,
    input  pred_taken, pred_target, mispredict, redirect_PC, branch_cnt, miss_cnt
  );

  modport slave (
    input  PC_IF, EX_valid, PC_EX, bcompare_in, target_EX, pred_taken_EX, pred_target_EX,
    output pred_taken, pred_target, mispredict, redirect_PC, branch_cnt, miss_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, trained by EX outcomes.
// Latency: prediction and mispredict/redirect are combinational; training lands at the next edge.
// Backpressure: none; one lookup and one training event are accepted every cycle.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  // BTB storage
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit;

  // Single write port into the BTB entry selected by PC_EX
  logic        upd_en;
  logic [31:0] upd_target_d;
  logic [1:0]  upd_ctr_d;

  assign if_idx = bp.PC_IF[IDX_BITS+1:2];
  assign if_tag = bp.PC_IF[31:IDX_BITS+2];
  assign ex_idx = bp.PC_EX[IDX_BITS+1:2];
  assign ex_tag = bp.PC_EX[31:IDX_BITS+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Lookup reads pre-update state only; a same-cycle write to this index is not bypassed.
  // Gating with reset keeps the fall-through prediction during reset explicit.
  assign bp.pred_taken  = reset && if_hit && ctr_q[if_idx][1];
  assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp.PC_IF + 32'd4;

  // A branch mispredicts on a wrong direction, or on a correct taken guess with a stale target
  assign bp.mispredict = bp.EX_valid &&
                         ((bp.bcompare_in != bp.pred_taken_EX) ||
                          (bp.bcompare_in && bp.pred_taken_EX &&
                           (bp.pred_target_EX != bp.target_EX)));
  assign bp.redirect_PC = bp.bcompare_in ? bp.target_EX : bp.PC_EX + 32'd4;

  assign bp.branch_cnt = branch_cnt_q;
  assign bp.miss_cnt   = miss_cnt_q;

  // Training decision: counter update on hit, allocation only on a taken miss
  always_comb begin
    upd_en       = 1'b0;
    upd_target_d = target_q[ex_idx];
    upd_ctr_d    = ctr_q[ex_idx];
    if (bp.EX_valid) begin
      if (ex_hit) begin
        upd_en = 1'b1;
        if (bp.bcompare_in) begin
          upd_target_d = bp.target_EX;
          upd_ctr_d    = (ctr_q[ex_idx] == 2'b11) ? 2'b11 : ctr_q[ex_idx] + 2'd1;
        end else begin
          upd_ctr_d    = (ctr_q[ex_idx] == 2'b00) ? 2'b00 : ctr_q[ex_idx] - 2'd1;
        end
      end else if (bp.bcompare_in) begin
        upd_en       = 1'b1;
        upd_target_d = bp.target_EX;
        upd_ctr_d    = 2'b10;
      end
    end
  end

  // Performance counters wrap naturally at 2^32
  always_comb begin
    branch_cnt_d = branch_cnt_q + {31'd0, bp.EX_valid};
    miss_cnt_d   = miss_cnt_q + {31'd0, bp.mispredict};
  end

  // BTB state; reset leaves every entry invalid and weakly not-taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= upd_target_d;
      ctr_q[ex_idx]    <= upd_ctr_d;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
endmodule
